// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiplier and multi-cycle divider.
// Owns the HI/LO registers and stalls EX until a MULT/DIV result lands in them.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no op in flight, accepts a new muldiv op
// MUL_WAIT | waiting MUL_LAT cycles for the multiplier product
// DIV_WAIT | divider running, waiting for div_ready
// DONE     | HI/LO written, EX released; held while ex_hold
module muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ex_hold,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        div_signed,
    output logic        div_start,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept_mul, accept_div, write_hi, write_lo;

    assign accept_mul = op_valid && (op == 3'd1 || op == 3'd2);
    // Divide by zero is architecturally undefined; it is dropped without stalling.
    assign accept_div = op_valid && (op == 3'd3 || op == 3'd4) && (src2 != 32'd0);
    assign write_hi   = op_valid && (op == 3'd5);
    assign write_lo   = op_valid && (op == 3'd6);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_mul)      state_nxt = MUL_WAIT;
                else if (accept_div) state_nxt = DIV_WAIT;
            end
            MUL_WAIT: if (cnt == '0) state_nxt = DONE;
            DIV_WAIT: if (div_ready) state_nxt = DONE;
            DONE:     if (!ex_hold)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            mul_ina    <= '0;
            mul_inb    <= '0;
            mul_signed <= 1'b0;
            div_op1    <= '0;
            div_op2    <= '0;
            div_signed <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (accept_mul) begin
                            mul_ina    <= src1;
                            mul_inb    <= src2;
                            mul_signed <= (op == 3'd1);
                            cnt        <= CNT_W'(MUL_LAT - 1);
                        end else if (accept_div) begin
                            div_op1    <= src1;
                            div_op2    <= src2;
                            div_signed <= (op == 3'd3);
                        end else if (write_hi) begin
                            hi <= src1;
                        end else if (write_lo) begin
                            lo <= src1;
                        end
                    end
                    MUL_WAIT: begin
                        if (cnt != '0) cnt <= cnt - 1'b1;
                        else           {hi, lo} <= mul_result;
                    end
                    DIV_WAIT: begin
                        if (div_ready) begin
                            hi <= div_result[63:32];
                            lo <= div_result[31:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign div_start = (state == DIV_WAIT) && !div_ready;
    assign div_annul = flush && (state == DIV_WAIT);
    assign stallreq  = !flush && (((state == IDLE) && (accept_mul || accept_div))
                                  || (state == MUL_WAIT) || (state == DIV_WAIT));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models
// and a queue of expected {hi,lo} results.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn, flush, op_valid, ex_hold;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic [31:0] mul_ina, mul_inb, div_op1, div_op2, hi, lo;
    logic        mul_signed, div_signed, div_start, div_annul, div_ready, stallreq, busy;
    logic [63:0] mul_result, div_result;

    int total = 0;
    int bad   = 0;
    int div_lat = 33;
    int div_cnt = 0;
    logic [63:0] sb[$];
    logic [63:0] prev;

    muldiv_ctrl #(.MUL_LAT(2), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .op_valid(op_valid), .op(op),
        .src1(src1), .src2(src2), .ex_hold(ex_hold),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_signed(mul_signed), .mul_result(mul_result),
        .div_op1(div_op1), .div_op2(div_op2), .div_signed(div_signed),
        .div_start(div_start), .div_annul(div_annul), .div_result(div_result),
        .div_ready(div_ready), .stallreq(stallreq), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: 64-bit product of sign- or zero-extended operands.
    logic [63:0] ext_a, ext_b;
    assign ext_a      = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
    assign ext_b      = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
    assign mul_result = ext_a * ext_b;

    // Divider model: result ready on the div_lat-th cycle of div_start.
    logic [31:0] q, r;
    always_comb begin
        q = 32'd0;
        r = 32'd0;
        if (div_op2 != 32'd0) begin
            if (div_signed) begin
                q = $signed(div_op1) / $signed(div_op2);
                r = $signed(div_op1) % $signed(div_op2);
            end else begin
                q = div_op1 / div_op2;
                r = div_op1 % div_op2;
            end
        end
    end
    assign div_result = {r, q};
    assign div_ready  = (div_cnt == div_lat - 1);

    always @(posedge clk) begin
        if (!resetn || div_annul || !div_start) div_cnt <= 0;
        else                                    div_cnt <= div_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_stall, input int hold);
        int          stalls;
        bit          done;
        logic [63:0] got, exp_q;
        @(negedge clk);
        op_valid = 1'b1; op = o; src1 = a; src2 = b;
        sb.push_back(exp);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (busy && !stallreq) done = 1'b1;
            else begin
                if (stallreq) stalls++;
                if (div_ready) check("div_start_fall", {63'd0, div_start}, 64'd0);
                @(negedge clk);
            end
        end
        check("reached_done", {63'd0, done}, 64'd1);
        got   = {hi, lo};
        exp_q = sb.pop_front();
        check("hilo", got, exp_q);
        check("stall_cycles", 64'(stalls), 64'(exp_stall));
        if (o == 3'd1 || o == 3'd2) check("mul_signed", {63'd0, mul_signed}, {63'd0, o == 3'd1});
        else                        check("div_signed", {63'd0, div_signed}, {63'd0, o == 3'd3});
        for (int h = 0; h < hold; h++) begin
            ex_hold = 1'b1;
            @(negedge clk); #1;
            check("hold_busy", {63'd0, busy}, 64'd1);
            check("hold_stall", {63'd0, stallreq}, 64'd0);
            check("hold_hilo", {hi, lo}, got);
        end
        ex_hold  = 1'b0;
        op_valid = 1'b0;
        @(negedge clk); #1;
        check("back_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; op_valid = 1'b0; ex_hold = 1'b0;
        op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stall", {63'd0, stallreq}, 64'd0);
        check("rst_mulops", {mul_ina, mul_inb}, 64'd0);
        check("rst_divops", {div_op1, div_op2}, 64'd0);
        check("rst_sign", {62'd0, mul_signed, div_signed}, 64'd0);
        check("rst_divstart", {63'd0, div_start}, 64'd0);
        resetn = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 3, 0);
        div_lat = 33;
        run_op(3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0);

        // divide by zero: dropped silently
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; src1 = 32'd5; src2 = 32'd0;
        #1;
        check("dz_stall", {63'd0, stallreq}, 64'd0);
        check("dz_start", {63'd0, div_start}, 64'd0);
        @(negedge clk); #1;
        check("dz_busy", {63'd0, busy}, 64'd0);
        check("dz_hilo", {hi, lo}, {32'd2, 32'd14});
        op_valid = 1'b0;

        // MTHI then MTLO back to back
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5; src1 = 32'hDEAD_BEEF;
        #1;
        check("mthi_stall", {63'd0, stallreq}, 64'd0);
        @(negedge clk);
        op = 3'd6; src1 = 32'h1234_5678;
        #1;
        check("mtlo_stall", {63'd0, stallreq}, 64'd0);
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

        // divide flushed on its 10th cycle in flight
        @(negedge clk);
        op_valid = 1'b1; op = 3'd4; src1 = 32'd1000; src2 = 32'd3;
        repeat (10) @(negedge clk);
        op_valid = 1'b0; flush = 1'b1;
        #1;
        check("fl_annul", {63'd0, div_annul}, 64'd1);
        check("fl_stall", {63'd0, stallreq}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_busy", {63'd0, busy}, 64'd0);
        check("fl_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 64'h00000001_FFFFFFFE, 3, 0);

        // div_ready and flush in the same cycle: flush wins
        div_lat = 4;
        @(negedge clk);
        op_valid = 1'b1; op = 3'd4; src1 = 32'd50; src2 = 32'd3;
        for (int i = 0; i < 20 && !div_ready; i++) @(negedge clk);
        check("sim_ready_seen", {63'd0, div_ready}, 64'd1);
        op_valid = 1'b0; flush = 1'b1;
        #1;
        check("sim_annul", {63'd0, div_annul}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("sim_busy", {63'd0, busy}, 64'd0);
        check("sim_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

        // MULT completing under ex_hold, then a signed divide
        run_op(3'd1, 32'h0000_0010, 32'hFFFF_FFFF, 64'hFFFFFFFF_FFFFFFF0, 3, 3);
        div_lat = 6;
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 7, 0);

        // reset in the middle of a multiply
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; src1 = 32'd9; src2 = 32'd9;
        @(negedge clk);
        resetn = 1'b0; op_valid = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        resetn = 1'b1;

        prev = {hi, lo};
        repeat (2) @(negedge clk);
        check("queue_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
